// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 8-bit registered arithmetic/logic unit.
//
// The result is computed combinationally from A, B and opcode. It is
// registered into ALU_Out on each rising clk edge, so latency is one cycle.
// rst_n low clears ALU_Out asynchronously and holds it at 0x00.
//
// Ports
//   clk      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous active-low reset
//   A        in   8  first operand, unsigned
//   B        in   8  second operand, unsigned
//   opcode   in   4  operation select (all 16 codes defined)
//   ALU_Out  out  8  registered result
//
// Configuration
//   ALU_DIV_EN  defined: opcode 0011 performs A / B (0xFF when B == 0) using
//               an unrolled single-cycle restoring divider.
//               undefined: no divider is built and opcode 0011 loads 0x00.
// ---------------------------------------------------------------------------

// One row of the restoring divider. It shifts the next dividend bit into the
// partial remainder, subtracts the divisor when the divisor fits, and emits
// the matching quotient bit.
module alu_div_stage (
  input  logic [7:0] rem_in,
  input  logic       num_bit,
  input  logic [7:0] divisor,
  output logic [7:0] rem_out,
  output logic       q_bit
);
  logic [8:0] trial;
  logic [8:0] diff;
  logic       stage_unused;

  assign trial = {rem_in, num_bit};
  assign diff  = trial - {1'b0, divisor};
  assign q_bit = (trial >= {1'b0, divisor});
  // rem_in < divisor on entry, so the kept remainder always fits in 8 bits.
  assign rem_out      = q_bit ? diff[7:0] : trial[7:0];
  assign stage_unused = diff[8];
endmodule

module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] opcode,
  output logic [7:0] ALU_Out
);
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SHL  = 4'b0100,
    OP_SHR  = 4'b0101,
    OP_ROL  = 4'b0110,
    OP_ROR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOR  = 4'b1011,
    OP_NAND = 4'b1100,
    OP_XNOR = 4'b1101,
    OP_GT   = 4'b1110,
    OP_EQ   = 4'b1111
  } alu_op_e;

  alu_op_e    op;
  logic [7:0] div_q;
  logic [7:0] result;

  assign op = alu_op_e'(opcode);

`ifdef ALU_DIV_EN
  // Unrolled restoring divider: row i consumes dividend bit A[7-i] and yields
  // quotient bit 7-i. With B == 0 every row already produces a 1, but the
  // 0xFF result is forced explicitly so the divide-by-zero case stays clear.
  logic [8:0][7:0] rem;
  logic [7:0]      quo;
  logic            div_rem_unused;

  assign rem[0] = 8'h00;

  for (genvar i = 0; i < 8; i++) begin : g_div
    alu_div_stage u_stage (
      .rem_in  (rem[i]),
      .num_bit (A[7-i]),
      .divisor (B),
      .rem_out (rem[i+1]),
      .q_bit   (quo[7-i])
    );
  end

  assign div_rem_unused = ^rem[8];
  assign div_q          = (B == 8'h00) ? 8'hFF : quo;
`else
  assign div_q = 8'h00;
`endif

  always_comb begin
    result = 8'h00;
    unique case (op)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;
      OP_DIV:  result = div_q;
      OP_SHL:  result = {A[6:0], 1'b0};
      OP_SHR:  result = {1'b0, A[7:1]};
      OP_ROL:  result = {A[6:0], A[7]};
      OP_ROR:  result = {A[0], A[7:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = {7'b0, (A > B)};
      OP_EQ:   result = {7'b0, (A == B)};
      default: result = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ALU_Out <= 8'h00;
    else        ALU_Out <= result;
  end
endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// A reference model computes each opcode with integer arithmetic. The model
// output is checked against ALU_Out on every falling clk edge. Directed
// vectors with hand-computed results pin both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_alu;
  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] opcode;
  logic [7:0] ALU_Out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;
  logic [7:0] exp_out = 8'h00;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .opcode  (opcode),
    .ALU_Out (ALU_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    int sa, sb, r;
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:  r = (sa + sb) % 256;
      4'd1:  r = (sa - sb + 256) % 256;
      4'd2:  r = (sa * sb) % 256;
`ifdef ALU_DIV_EN
      4'd3:  r = (sb == 0) ? 255 : sa / sb;
`else
      4'd3:  r = 0;
`endif
      4'd4:  r = (sa * 2) % 256;
      4'd5:  r = sa / 2;
      4'd6:  r = (sa * 2) % 256 + sa / 128;
      4'd7:  r = sa / 2 + (sa % 2) * 128;
      4'd8:  r = int'(a & b);
      4'd9:  r = int'(a | b);
      4'd10: r = int'(a ^ b);
      4'd11: r = 255 - int'(a | b);
      4'd12: r = 255 - int'(a & b);
      4'd13: r = 255 - int'(a ^ b);
      4'd14: r = (sa > sb) ? 1 : 0;
      default: r = (sa == sb) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Model register: the result captured at each rising edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_out = 8'h00;
    else        exp_out = ref_alu(A, B, opcode);
  end

  always @(negedge clk) begin
    if (chk_en) check("cycle", ALU_Out, exp_out);
  end

  // Directed vector: drive after an edge, check the literal after the next edge,
  // and confirm the model agrees with the same literal.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] lit, input string name);
    @(posedge clk);
    #2;
    A = a; B = b; opcode = op;
    @(posedge clk);
    #1;
    check(name, ALU_Out, lit);
    check({"model_", name}, ref_alu(a, b, op), lit);
  endtask

  initial begin
    rst_n = 1'b0; A = 8'h00; B = 8'h00; opcode = 4'h0;
    #2;
    check("reset_state", ALU_Out, 8'h00);
    #10;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(8'h01, 8'h01, 4'b0000, 8'h02, "add_1_1");
    do_op(8'h0A, 8'h05, 4'b0000, 8'h0F, "add_a_5");
    do_op(8'hFF, 8'h01, 4'b0000, 8'h00, "add_wrap");
    do_op(8'h05, 8'h0A, 4'b0001, 8'hFB, "sub_wrap");
    do_op(8'h10, 8'h11, 4'b0010, 8'h10, "mul_low");
    do_op(8'h81, 8'h00, 4'b0100, 8'h02, "shl");
    do_op(8'h81, 8'h00, 4'b0101, 8'h40, "shr");
    do_op(8'h81, 8'h00, 4'b0110, 8'h03, "rol");
    do_op(8'h81, 8'h00, 4'b0111, 8'hC0, "ror");
    do_op(8'hF0, 8'h3C, 4'b1000, 8'h30, "and");
    do_op(8'hF0, 8'h3C, 4'b1001, 8'hFC, "or");
    do_op(8'hF0, 8'h3C, 4'b1010, 8'hCC, "xor");
    do_op(8'hF0, 8'h3C, 4'b1011, 8'h03, "nor");
    do_op(8'hF0, 8'h3C, 4'b1100, 8'hCF, "nand");
    do_op(8'hF0, 8'h3C, 4'b1101, 8'h33, "xnor");
    do_op(8'h0A, 8'h05, 4'b1110, 8'h01, "gt_true");
    do_op(8'h05, 8'h0A, 4'b1110, 8'h00, "gt_false");
    do_op(8'h05, 8'h05, 4'b1111, 8'h01, "eq_true");
    do_op(8'h05, 8'h06, 4'b1111, 8'h00, "eq_false");
`ifdef ALU_DIV_EN
    do_op(8'h0A, 8'h03, 4'b0011, 8'h03, "div");
    do_op(8'h0A, 8'h00, 4'b0011, 8'hFF, "div_zero");
    do_op(8'hFF, 8'h01, 4'b0011, 8'hFF, "div_by_one");
`else
    do_op(8'h0A, 8'h03, 4'b0011, 8'h00, "div_off");
    do_op(8'h0A, 8'h00, 4'b0011, 8'h00, "div_off_zero");
`endif

    // Asynchronous reset: load 0x2A, then pull rst_n low between edges.
    do_op(8'h20, 8'h0A, 4'b0000, 8'h2A, "pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", ALU_Out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", ALU_Out, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    check("release_no_edge", ALU_Out, 8'h00);
    @(posedge clk);
    #1;
    check("first_after_release", ALU_Out, 8'h2A);

    // Randomized phase, biased towards B == 0 and A == B, with one reset pulse.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      A      = 8'($urandom);
      B      = 8'($urandom);
      opcode = 4'($urandom);
      case ($urandom_range(7))
        0: B = 8'h00;
        1: B = A;
        default: ;
      endcase
      if (i == 200) rst_n = 1'b0;
      if (i == 201) rst_n = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
